issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard_if.sv | 50 +++++
 rtl/issue_scoreboard.sv | 158 +++++++++++++++
 tb/tb_issue_scoreboard.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Issue/result/retire handshake and hazard-report bundle between the
// decode stage, the execute/writeback stages and the issue scoreboard.
interface issue_scoreboard_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned TAGW = $clog2(DEPTH);

    logic            issue_valid;
    logic            issue_ready;
    logic [4:0]      issue_rd;
    logic            issue_gpr_we;
    logic [1:0]      issue_csr_rd;
    logic            issue_csr_we;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [1:0]      csr_rs;
    logic            use_rs1;
    logic            use_rs2;
    logic            use_csr;
    logic            result_valid;
    logic            retire;
    logic            flush;
    logic            fwd1_en;
    logic [TAGW-1:0] fwd1_tag;
    logic            fwd2_en;
    logic [TAGW-1:0] fwd2_tag;
    logic            fwdc_en;
    logic [TAGW-1:0] fwdc_tag;
    logic            stall_raw;
    logic            stall_full;
    logic [TAGW:0]   count;
    logic            empty;
    logic            err;

    modport master (
        output issue_valid, issue_rd, issue_gpr_we, issue_csr_rd, issue_csr_we,
               rs1, rs2, csr_rs, use_rs1, use_rs2, use_csr,
               result_valid, retire, flush,
        input  issue_ready, fwd1_en, fwd1_tag, fwd2_en, fwd2_tag, fwdc_en, fwdc_tag,
               stall_raw, stall_full, count, empty, err
    );

    modport slave (
        input  issue_valid, issue_rd, issue_gpr_we, issue_csr_rd, issue_csr_we,
               rs1, rs2, csr_rs, use_rs1, use_rs2, use_csr,
               result_valid, retire, flush,
        output issue_ready, fwd1_en, fwd1_tag, fwd2_en, fwd2_tag, fwdc_en, fwdc_tag,
               stall_raw, stall_full, count, empty, err
    );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks in-flight destinations in a circular FIFO
// and reports RAW stalls or forwarding tags for the instruction being issued.
module issue_scoreboard #(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    issue_scoreboard_if.slave  bus
);
    localparam int unsigned TAGW = $clog2(DEPTH);
    localparam int unsigned CNTW = TAGW + 1;

    typedef struct packed {
        logic       valid;
        logic       gpr_we;
        logic [4:0] rd;
        logic       csr_we;
        logic [1:0] csr_rd;
        logic       rdy;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    logic [TAGW-1:0] head_q, head_d;
    logic [TAGW-1:0] tail_q, tail_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            err_q, err_d;

    logic            hit1, hit2, hitc;
    logic            rdy1, rdy2, rdyc;
    logic [TAGW-1:0] tag1, tag2, tagc;
    logic            raw1, raw2, rawc;
    logic            full;
    logic            stall_raw;
    logic            push;
    logic            res_found;
    logic [TAGW-1:0] res_idx;
    logic            retire_ok;

    // Youngest-match search: walk oldest to youngest so the last hit wins.
    always_comb begin
        hit1 = 1'b0; rdy1 = 1'b0; tag1 = '0;
        hit2 = 1'b0; rdy2 = 1'b0; tag2 = '0;
        hitc = 1'b0; rdyc = 1'b0; tagc = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_q[head_q + TAGW'(k)].valid && ent_q[head_q + TAGW'(k)].gpr_we &&
                ent_q[head_q + TAGW'(k)].rd == bus.rs1) begin
                hit1 = 1'b1;
                rdy1 = ent_q[head_q + TAGW'(k)].rdy;
                tag1 = head_q + TAGW'(k);
            end
            if (ent_q[head_q + TAGW'(k)].valid && ent_q[head_q + TAGW'(k)].gpr_we &&
                ent_q[head_q + TAGW'(k)].rd == bus.rs2) begin
                hit2 = 1'b1;
                rdy2 = ent_q[head_q + TAGW'(k)].rdy;
                tag2 = head_q + TAGW'(k);
            end
            if (ent_q[head_q + TAGW'(k)].valid && ent_q[head_q + TAGW'(k)].csr_we &&
                ent_q[head_q + TAGW'(k)].csr_rd == bus.csr_rs) begin
                hitc = 1'b1;
                rdyc = ent_q[head_q + TAGW'(k)].rdy;
                tagc = head_q + TAGW'(k);
            end
        end
    end

    assign raw1      = bus.use_rs1 && hit1 && !rdy1;
    assign raw2      = bus.use_rs2 && hit2 && !rdy2;
    assign rawc      = bus.use_csr && hitc && !rdyc;
    assign stall_raw = raw1 || raw2 || rawc;
    assign full      = (count_q == CNTW'(DEPTH));

    assign bus.fwd1_en     = bus.use_rs1 && hit1 && rdy1;
    assign bus.fwd2_en     = bus.use_rs2 && hit2 && rdy2;
    assign bus.fwdc_en     = bus.use_csr && hitc && rdyc;
    assign bus.fwd1_tag    = bus.fwd1_en ? tag1 : '0;
    assign bus.fwd2_tag    = bus.fwd2_en ? tag2 : '0;
    assign bus.fwdc_tag    = bus.fwdc_en ? tagc : '0;
    assign bus.stall_raw   = stall_raw;
    assign bus.stall_full  = full;
    assign bus.issue_ready = !stall_raw && !full;
    assign bus.count       = count_q;
    assign bus.empty       = (count_q == '0);
    assign bus.err         = err_q;

    assign push = bus.issue_valid && bus.issue_ready;

    // Oldest entry still awaiting a result: scan youngest to oldest, last hit wins.
    always_comb begin
        res_found = 1'b0;
        res_idx   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_q[head_q + TAGW'(k)].valid && !ent_q[head_q + TAGW'(k)].rdy) begin
                res_found = 1'b1;
                res_idx   = head_q + TAGW'(k);
            end
        end
    end

    // A result landing on the head in the same cycle lets that retire succeed.
    assign retire_ok = bus.retire && (count_q != '0) && ent_q[head_q].valid &&
                       (ent_q[head_q].rdy ||
                        (bus.result_valid && res_found && (res_idx == head_q)));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;

        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (bus.result_valid) begin
                if (res_found) ent_d[res_idx].rdy = 1'b1;
                else           err_d = 1'b1;
            end
            if (bus.retire) begin
                if (retire_ok) begin
                    ent_d[head_q] = '0;
                    head_d        = head_q + TAGW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            if (push) begin
                ent_d[tail_q].valid  = 1'b1;
                ent_d[tail_q].gpr_we = bus.issue_gpr_we && (bus.issue_rd != 5'd0);
                ent_d[tail_q].rd     = bus.issue_rd;
                ent_d[tail_q].csr_we = bus.issue_csr_we;
                ent_d[tail_q].csr_rd = bus.issue_csr_rd;
                ent_d[tail_q].rdy    = 1'b0;
                tail_d               = tail_q + TAGW'(1);
            end
            count_d = count_q + CNTW'(push) - CNTW'(retire_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hand-computed hazard, forward, count
// and error expectations over a sequence of short scenarios.
module tb_issue_scoreboard;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    issue_scoreboard_if #(.DEPTH(4)) bus ();

    issue_scoreboard #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        bus.issue_valid  = 1'b0;
        bus.issue_rd     = 5'd0;
        bus.issue_gpr_we = 1'b0;
        bus.issue_csr_rd = 2'd0;
        bus.issue_csr_we = 1'b0;
        bus.rs1          = 5'd0;
        bus.rs2          = 5'd0;
        bus.csr_rs       = 2'd0;
        bus.use_rs1      = 1'b0;
        bus.use_rs2      = 1'b0;
        bus.use_csr      = 1'b0;
        bus.result_valid = 1'b0;
        bus.retire       = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gpr(input logic [4:0] rd);
        clr();
        bus.issue_valid  = 1'b1;
        bus.issue_rd     = rd;
        bus.issue_gpr_we = 1'b1;
        step();
        clr();
    endtask

    task automatic pulse_result();
        clr();
        bus.result_valid = 1'b1;
        step();
        clr();
    endtask

    task automatic do_flush();
        clr();
        bus.flush = 1'b1;
        step();
        clr();
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        #12;
        chk("rst_count",  32'(bus.count), 0);
        chk("rst_empty",  32'(bus.empty), 1);
        chk("rst_ready",  32'(bus.issue_ready), 1);
        chk("rst_err",    32'(bus.err), 0);
        chk("rst_raw",    32'(bus.stall_raw), 0);
        chk("rst_full",   32'(bus.stall_full), 0);
        rst_n = 1'b1;
        step();

        // RAW stall then forward after result
        push_gpr(5'd5);
        bus.rs1 = 5'd5; bus.use_rs1 = 1'b1; #1;
        chk("raw_stall",  32'(bus.stall_raw), 1);
        chk("raw_ready",  32'(bus.issue_ready), 0);
        chk("raw_fwd1en", 32'(bus.fwd1_en), 0);
        chk("raw_count",  32'(bus.count), 1);
        bus.result_valid = 1'b1;
        step();
        bus.result_valid = 1'b0; #1;
        chk("fwd1_en",    32'(bus.fwd1_en), 1);
        chk("fwd1_tag",   32'(bus.fwd1_tag), 0);
        chk("fwd1_ready", 32'(bus.issue_ready), 1);
        clr(); bus.retire = 1'b1; step(); clr(); #1;
        chk("ret1_count", 32'(bus.count), 0);
        chk("ret1_err",   32'(bus.err), 0);
        do_flush();

        // Youngest match wins
        push_gpr(5'd3);
        push_gpr(5'd3);
        pulse_result();
        pulse_result();
        bus.rs2 = 5'd3; bus.use_rs2 = 1'b1; #1;
        chk("young_en",   32'(bus.fwd2_en), 1);
        chk("young_tag",  32'(bus.fwd2_tag), 1);
        bus.retire = 1'b1; step(); bus.retire = 1'b0; #1;
        chk("young_tag2", 32'(bus.fwd2_tag), 1);
        chk("young_cnt",  32'(bus.count), 1);
        push_gpr(5'd6);
        chk("cnt_two",    32'(bus.count), 2);
        clr(); bus.retire = 1'b1; step(); clr(); #1;
        chk("cnt_one",    32'(bus.count), 1);
        // result and retire together on the same not-ready head
        bus.result_valid = 1'b1; bus.retire = 1'b1; step(); clr(); #1;
        chk("rvret_cnt",  32'(bus.count), 0);
        chk("rvret_err",  32'(bus.err), 0);
        chk("rvret_empty", 32'(bus.empty), 1);
        do_flush();

        // Full with rd=0 entries, then illegal retire
        for (int i = 0; i < 4; i++) push_gpr(5'd0);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.issue_gpr_we = 1'b1;
        bus.rs1 = 5'd0; bus.use_rs1 = 1'b1; #1;
        chk("full_count", 32'(bus.count), 4);
        chk("full_stall", 32'(bus.stall_full), 1);
        chk("full_ready", 32'(bus.issue_ready), 0);
        chk("full_raw",   32'(bus.stall_raw), 0);
        step();
        chk("full_nopush", 32'(bus.count), 4);
        clr(); bus.retire = 1'b1; step(); clr(); #1;
        chk("bad_ret_err", 32'(bus.err), 1);
        chk("bad_ret_cnt", 32'(bus.count), 4);
        do_flush();
        chk("flush_cnt",  32'(bus.count), 0);
        chk("flush_err",  32'(bus.err), 1);

        // CSR hazard
        clr();
        bus.issue_valid = 1'b1; bus.issue_csr_rd = 2'b01; bus.issue_csr_we = 1'b1;
        step(); clr();
        bus.csr_rs = 2'b01; bus.use_csr = 1'b1; #1;
        chk("csr_raw",    32'(bus.stall_raw), 1);
        chk("csr_ready",  32'(bus.issue_ready), 0);
        bus.use_csr = 1'b0; #1;
        chk("csr_unused", 32'(bus.issue_ready), 1);
        bus.use_csr = 1'b1; bus.csr_rs = 2'b10; #1;
        chk("csr_other",  32'(bus.stall_raw), 0);
        bus.csr_rs = 2'b01; bus.result_valid = 1'b1; step(); bus.result_valid = 1'b0; #1;
        chk("csr_fwd_en", 32'(bus.fwdc_en), 1);
        chk("csr_fwd_tg", 32'(bus.fwdc_tag), 0);
        do_flush();

        // Full of ready entries, retire/push overlap and tail wrap
        for (int i = 1; i <= 4; i++) push_gpr(5'(i));
        for (int i = 0; i < 4; i++) pulse_result();
        #1;
        chk("wrap_full",  32'(bus.stall_full), 1);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.issue_gpr_we = 1'b1;
        bus.retire = 1'b1; #1;
        chk("wrap_nordy", 32'(bus.issue_ready), 0);
        step();
        chk("wrap_cnt3",  32'(bus.count), 3);
        chk("wrap_rdy",   32'(bus.issue_ready), 1);
        step();
        chk("wrap_same",  32'(bus.count), 3);
        pulse_result();
        bus.rs1 = 5'd7; bus.use_rs1 = 1'b1; bus.rs2 = 5'd4; bus.use_rs2 = 1'b1; #1;
        chk("wrap_tag0",  32'(bus.fwd1_tag), 0);
        chk("wrap_tag3",  32'(bus.fwd2_tag), 3);
        push_gpr(5'd8);
        chk("wrap_cnt4",  32'(bus.count), 4);
        pulse_result();
        bus.rs1 = 5'd8; bus.use_rs1 = 1'b1; #1;
        chk("wrap_tag1",  32'(bus.fwd1_tag), 1);
        do_flush();
        chk("wflush_cnt", 32'(bus.count), 0);
        chk("wflush_emp", 32'(bus.empty), 1);

        // Asynchronous reset mid-stream
        for (int i = 1; i <= 3; i++) push_gpr(5'(i + 10));
        chk("pre_rst_cnt", 32'(bus.count), 3);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_cnt",   32'(bus.count), 0);
        chk("arst_ready", 32'(bus.issue_ready), 1);
        chk("arst_err",   32'(bus.err), 0);
        chk("arst_empty", 32'(bus.empty), 1);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst",   32'(bus.count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
